// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial RAM/IO arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } arb_state_e;

  // Access length codes as presented on mem_len_in.
  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] LEN2 = 3'd2;
  localparam logic [2:0] LEN4 = 3'd4;

  // First address of the memory-mapped IO region.
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Byte count of an access; any unsupported code is a full word.
  function automatic logic [2:0] len_bytes(input logic [2:0] len);
    case (len)
      LEN1:    return LEN1;
      LEN2:    return LEN2;
      default: return LEN4;
    endcase
  endfunction

  // Little-endian byte lane of a 32-bit word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between instruction fetch and the MEM stage on a
// single byte-wide RAM/IO port. MEM has priority; each access is split into
// per-byte RAM cycles and completes with a one-cycle done pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              io_buffer_full_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_inst_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [2:0]        mem_len_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [ADDR_W-1:0] ram_a_out,
  output logic              ram_wr_out
);

  arb_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;       // reads: edges since accept; writes: bytes issued
  logic [2:0]        len_q, len_d;       // byte count of the current access
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdbuf_q, rdbuf_d;   // lanes assembled so far, zero above
  logic [ADDR_W-1:0] a_q, a_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [ADDR_W-1:0] byte_addr;
  logic              io_stall;
  logic              mem_accept_stall;

  assign byte_addr        = base_q + ADDR_W'(cnt_q);
  assign io_stall         = (byte_addr >= IO_BASE) && io_buffer_full_in;
  assign mem_accept_stall = (mem_addr_in >= IO_BASE) && io_buffer_full_in;

  // Next-state, byte sequencing and lane assembly.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rdbuf_d     = rdbuf_q;
    a_d         = a_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // A requester whose done is still high is ignored so it is not restarted.
        if (mem_req_in && !mem_done_q) begin
          base_d  = mem_addr_in;
          len_d   = len_bytes(mem_len_in);
          wdata_d = mem_wdata_in;
          rdbuf_d = '0;
          cnt_d   = '0;
          a_d     = mem_addr_in;
          if (mem_we_in) begin
            state_d = ST_MEM_WR;
            if (!mem_accept_stall) begin
              dout_d = mem_wdata_in[7:0];
              wr_d   = 1'b1;
              cnt_d  = 3'd1;
            end
          end else begin
            state_d = ST_MEM_RD;
          end
        end else if (if_req_in && !if_done_q && !flush_in) begin
          state_d = ST_IF_RD;
          base_d  = if_addr_in;
          len_d   = LEN4;
          rdbuf_d = '0;
          cnt_d   = '0;
          a_d     = if_addr_in;
        end
      end

      ST_IF_RD, ST_MEM_RD: begin
        if (state_q == ST_IF_RD && flush_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          // Address k is issued at edge k; byte k lands two edges later.
          if (cnt_q + 3'd1 < len_q) a_d = base_q + ADDR_W'(cnt_q + 3'd1);
          case (cnt_q)
            3'd1:    rdbuf_d[7:0]   = ram_din_in;
            3'd2:    rdbuf_d[15:8]  = ram_din_in;
            3'd3:    rdbuf_d[23:16] = ram_din_in;
            3'd4:    rdbuf_d[31:24] = ram_din_in;
            default: ;
          endcase
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (state_q == ST_IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = rdbuf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rdbuf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_MEM_WR: begin
        if (cnt_q == len_q) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end else if (!io_stall) begin
          a_d    = byte_addr;
          dout_d = byte_lane(wdata_q, cnt_q[1:0]);
          wr_d   = 1'b1;
          cnt_d  = cnt_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdbuf_q     <= '0;
      a_q         <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else if (rdy_in) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rdbuf_q     <= rdbuf_d;
      a_q         <= a_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done_out   = if_done_q;
  assign if_inst_out   = if_inst_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;
  assign ram_a_out     = a_q;
  assign ram_dout_out  = dout_q;
  // A held write strobe must not repeat a write while the system is frozen.
  assign ram_wr_out    = wr_q & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, io_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req, mem_we;
  logic [2:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .io_buffer_full_in(io_full),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_done_out(if_done), .if_inst_out(if_inst),
    .mem_req_in(mem_req), .mem_we_in(mem_we), .mem_len_in(mem_len), .mem_addr_in(mem_addr),
    .mem_wdata_in(mem_wdata), .mem_done_out(mem_done), .mem_rdata_out(mem_rdata),
    .ram_din_in(ram_din), .ram_dout_out(ram_dout), .ram_a_out(ram_a), .ram_wr_out(ram_wr)
  );

  always #5 clk = ~clk;

  // RAM model: address sampled at an edge, data out after it; holds when rdy is low.
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  logic [7:0] ram [0:262143];
  wr_t        wlog[$];
  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) begin
        ram[ram_a[17:0]] <= ram_dout;
        wlog.push_back('{ram_a, ram_dout});
      end
      ram_din <= ram[ram_a[17:0]];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cycles;
    int          gap_at;
    int          gap_len;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One MEM access; rdy is held low for gap_len cycles starting gap_at cycles in.
  task automatic mem_access(input vec_t v, output logic [31:0] rdata, output int cyc);
    mem_req = 1'b1; mem_we = v.we; mem_len = v.len; mem_addr = v.addr; mem_wdata = v.wdata;
    cyc = 0;
    while (cyc < 60) begin
      rdy = !(cyc >= v.gap_at && cyc < v.gap_at + v.gap_len);
      if (!rdy) begin
        #1;
        check("wr_gated_by_rdy", {63'd0, ram_wr}, 64'd0);
      end
      tick();
      cyc++;
      if (mem_done) break;
    end
    check("mem_done_seen", {63'd0, mem_done}, 64'd1);
    rdy = 1'b1;
    mem_req = 1'b0;
    rdata = mem_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mdata, idata;
    int          cyc, mcyc, icyc, w0;
    bit          bad, seen203, done_seen;

    // Hand-computed vectors: reads take N+2 cycles to done, writes N+1.
    vecs[0]  = '{1'b1, LEN4, 32'h0000_0100, 32'h0000_0013, 32'h0, 5, 99, 0};
    vecs[1]  = '{1'b1, LEN4, 32'h0000_0200, 32'h4433_2211, 32'h0, 5, 99, 0};
    vecs[2]  = '{1'b1, LEN4, 32'h0000_0400, 32'h0BAD_F00D, 32'h0, 5, 99, 0};
    vecs[3]  = '{1'b1, LEN4, 32'h0000_0500, 32'hDEAD_BEEF, 32'h0, 5, 99, 0};
    vecs[4]  = '{1'b0, LEN4, 32'h0000_0500, 32'h0, 32'hDEAD_BEEF, 6, 99, 0};
    vecs[5]  = '{1'b0, LEN2, 32'h0000_0502, 32'h0, 32'h0000_DEAD, 4, 99, 0};
    vecs[6]  = '{1'b0, LEN1, 32'h0000_0501, 32'h0, 32'h0000_00BE, 3, 99, 0};
    vecs[7]  = '{1'b1, LEN1, 32'h0000_0501, 32'h1234_5677, 32'h0, 2, 99, 0};
    vecs[8]  = '{1'b0, LEN4, 32'h0000_0500, 32'h0, 32'hDEAD_77EF, 6, 99, 0};
    vecs[9]  = '{1'b1, 3'd3, 32'h0000_0600, 32'h0102_0304, 32'h0, 5, 99, 0};
    vecs[10] = '{1'b0, 3'd0, 32'h0000_0600, 32'h0, 32'h0102_0304, 6, 99, 0};
    vecs[11] = '{1'b1, LEN4, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0, 5, 99, 0};
    vecs[12] = '{1'b0, LEN4, 32'hFFFF_FFFE, 32'h0, 32'hA1B2_C3D4, 6, 99, 0};
    vecs[13] = '{1'b1, LEN2, 32'h0000_0800, 32'h0000_BEEF, 32'h0, 5, 1, 2};
    vecs[14] = '{1'b0, LEN2, 32'h0000_0800, 32'h0, 32'h0000_BEEF, 6, 2, 2};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = LEN1; mem_addr = '0; mem_wdata = '0;
    tick(); tick();

    // Reset state.
    check("rst_if_done",   {63'd0, if_done},  64'd0);
    check("rst_if_inst",   {32'd0, if_inst},  64'd0);
    check("rst_mem_done",  {63'd0, mem_done}, 64'd0);
    check("rst_mem_rdata", {32'd0, mem_rdata}, 64'd0);
    check("rst_ram_a",     {32'd0, ram_a},    64'd0);
    check("rst_ram_dout",  {56'd0, ram_dout}, 64'd0);
    check("rst_ram_wr",    {63'd0, ram_wr},   64'd0);
    rst = 1'b0;
    tick();

    // Table of MEM accesses.
    foreach (vecs[i]) begin
      mem_access(vecs[i], rd, cyc);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cycles));
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].rdata});
      tick();
    end

    // IF fetch alone: addresses on consecutive cycles, single done pulse after E5.
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("if_addr_e%0d", k), {32'd0, ram_a}, 64'(32'h100 + k));
      check($sformatf("if_nodone_e%0d", k), {63'd0, if_done}, 64'd0);
    end
    tick();
    check("if_nodone_e4", {63'd0, if_done}, 64'd0);
    tick();
    check("if_done_e5", {63'd0, if_done}, 64'd1);
    check("if_inst",    {32'd0, if_inst}, 64'h13);
    if_req = 1'b0;
    tick();
    check("if_done_one_cycle", {63'd0, if_done}, 64'd0);
    tick();

    // Simultaneous requests: MEM first, IF accepted in MEM's done cycle.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = LEN4; mem_addr = 32'h200;
    bad = 1'b0; seen203 = 1'b0; mcyc = 0; icyc = 0; mdata = '0; idata = '0;
    for (int c = 1; c <= 40 && icyc == 0; c++) begin
      tick();
      if (ram_a == 32'h203) seen203 = 1'b1;
      if (ram_a == 32'h100 && !seen203) bad = 1'b1;
      if (mem_done) begin mcyc = c; mdata = mem_rdata; mem_req = 1'b0; end
      if (if_done)  begin icyc = c; idata = if_inst;   if_req  = 1'b0; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("both_mem_cycle", 64'(mcyc), 64'd6);
    check("both_mem_rdata", {32'd0, mdata}, 64'h4433_2211);
    check("both_if_cycle",  64'(icyc), 64'd12);
    check("both_if_inst",   {32'd0, idata}, 64'h13);
    check("both_if_before_mem", {63'd0, bad}, 64'd0);
    tick();

    // Store halfword: two write cycles, little-endian bytes.
    w0 = wlog.size();
    mem_access('{1'b1, LEN2, 32'h300, 32'hAABB_CCDD, 32'h0, 3, 99, 0}, rd, cyc);
    check("sh_cycles", 64'(cyc), 64'd3);
    check("sh_nwrites", 64'(wlog.size() - w0), 64'd2);
    if (wlog.size() >= w0 + 2) begin
      check("sh_w0", {24'd0, wlog[w0].a,   wlog[w0].d},   {24'd0, 32'h300, 8'hDD});
      check("sh_w1", {24'd0, wlog[w0+1].a, wlog[w0+1].d}, {24'd0, 32'h301, 8'hCC});
    end
    tick();

    // IO write stall for three cycles.
    io_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = LEN1; mem_addr = 32'h0003_0000; mem_wdata = 32'h41;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("io_stall_wr%0d", k), {63'd0, ram_wr}, 64'd0);
    end
    io_full = 1'b0;
    tick();
    check("io_wr",      {63'd0, ram_wr},   64'd1);
    check("io_dout",    {56'd0, ram_dout}, 64'h41);
    check("io_addr",    {32'd0, ram_a},    64'h0003_0000);
    check("io_no_done", {63'd0, mem_done}, 64'd0);
    tick();
    check("io_wr_off", {63'd0, ram_wr},   64'd0);
    check("io_done",   {63'd0, mem_done}, 64'd1);
    mem_req = 1'b0;
    tick();

    // Flush at E2 of a fetch, then a redirected fetch from 0x400.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    flush = 1'b1; if_addr = 32'h400;
    done_seen = if_done;
    tick();
    flush = 1'b0;
    done_seen = done_seen | if_done;
    check("flush_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    tick();
    check("flush_new_addr", {32'd0, ram_a}, 64'h400);
    icyc = 0;
    for (int c = 1; c <= 20 && icyc == 0; c++) begin
      if (if_done) icyc = c;
      if (icyc == 0) tick();
    end
    if_req = 1'b0;
    check("flush_no_done",  {63'd0, done_seen}, 64'd0);
    check("flush_refetch_cycle", 64'(icyc), 64'd6);
    check("flush_refetch_inst",  {32'd0, if_inst}, 64'h0BAD_F00D);
    tick();

    // Async reset in the middle of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = LEN4; mem_addr = 32'h700; mem_wdata = 32'h5566_7788;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("mrst_mem_done", {63'd0, mem_done}, 64'd0);
    check("mrst_if_inst",  {32'd0, if_inst},  64'd0);
    check("mrst_rdata",    {32'd0, mem_rdata}, 64'd0);
    check("mrst_ram_a",    {32'd0, ram_a},    64'd0);
    check("mrst_ram_dout", {56'd0, ram_dout}, 64'd0);
    check("mrst_ram_wr",   {63'd0, ram_wr},   64'd0);
    check("mrst_state",    64'(dut.state_q),  64'(ST_IDLE));
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    // Bytes 0 and 1 reached the RAM before reset; no rollback.
    mem_access('{1'b0, LEN2, 32'h700, 32'h0, 32'h0, 4, 99, 0}, rd, cyc);
    check("post_rst_cycles", 64'(cyc), 64'd4);
    check("post_rst_rdata",  {32'd0, rd}, 64'h0000_7788);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
